video_timing_gen: RTL and testbench

Raster timing and test-source generator for the HDMI video path. Counts pixels and lines on the shared pixel clock gated by the video clock enable. Produces the `{Vblank, Hblank}` blanking pair, the `{D_sync, Vsync, Hsync}` sync triple and a 24-bit RGB stream. Sits directly upstream of `video_uut` and drives its `vh_blank_i`, `dvh_sync_i` and `vid_rgb_i` inputs; default timing is CEA-861 1080p (2200 x 1125 total).

---
 rtl/video_timing_gen.sv | 137 +++++++++++++
 tb/tb_video_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing and test-source generator for the HDMI video path. Counts
// pixels (h) and lines (v) on the pixel clock, advancing only when the video
// clock enable is high, and presents the blanking pair, sync triple, RGB test
// source and pixel coordinates for one pixel per enabled cycle. All outputs
// are registered from the same counter state, so they always describe the
// same pixel. Default timing is CEA-861 1080p (2200 x 1125 total).
//
// Handshake: there is no valid/ready pair. cen_i is a plain qualifier: on a
// clock edge with cen_i high the outputs load the decode of the current
// (h,v) and the counters step; with cen_i low everything holds. rst_i
// overrides cen_i.
//
// Ports:
//   clk_i       pixel clock (only clock)
//   rst_i       synchronous active-high reset
//   cen_i       video clock enable
//   vh_blank_o  {Vblank, Hblank}
//   dvh_sync_o  {D_sync (data enable), Vsync, Hsync}
//   vid_rgb_o   {R[23:16], G[15:8], B[7:0]}; black outside active video
//   hcount_o    h of the pixel on the outputs
//   vcount_o    v of the pixel on the outputs
//   sof_o       high for the pixel at (0,0)
//
// Configuration macro: VTG_COLOUR_BARS_EN
//   defined   -> 8 vertical colour bars across active video
//   undefined -> flat mid-grey 24'h808080 across active video
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] hcount_o,
  output logic [11:0] vcount_o,
  output logic        sof_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOT - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL        = (SYNC_POL != 0);

  logic [11:0] h_q;
  logic [11:0] v_q;

  // Combinational decode of the current counter position.
  logic        hblank_d;
  logic        vblank_d;
  logic        de_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        sof_d;
  logic [23:0] rgb_active;
  logic [23:0] rgb_d;

`ifdef VTG_COLOUR_BARS_EN
  localparam int          BAR_W  = H_ACTIVE / 8;
  localparam logic [11:0] BAR_WV = 12'(BAR_W);

  logic [11:0] bar_raw;
  logic [2:0]  bar;

  always_comb begin
    bar_raw = h_q / BAR_WV;
    // Clamp covers H_ACTIVE values not divisible by 8.
    bar     = (bar_raw > 12'd7) ? 3'd7 : bar_raw[2:0];
    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
    // directly onto inverted index bits: R = ~bar[1], G = ~bar[2], B = ~bar[0].
    rgb_active = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end
`else
  always_comb begin
    rgb_active = 24'h808080;
  end
`endif

  always_comb begin
    hblank_d = (h_q >= H_ACT_END);
    vblank_d = (v_q >= V_ACT_END);
    de_d     = ~hblank_d & ~vblank_d;
    // Vsync decodes from v only, so it is inherently line-aligned.
    hsync_d  = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? POL : ~POL;
    vsync_d  = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? POL : ~POL;
    sof_d    = (h_q == 12'd0) && (v_q == 12'd0);
    rgb_d    = de_d ? rgb_active : 24'h000000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q        <= 12'd0;
      v_q        <= 12'd0;
      vh_blank_o <= 2'b11;
      dvh_sync_o <= {1'b0, ~POL, ~POL};
      vid_rgb_o  <= 24'h000000;
      hcount_o   <= 12'd0;
      vcount_o   <= 12'd0;
      sof_o      <= 1'b0;
    end else if (cen_i) begin
      vh_blank_o <= {vblank_d, hblank_d};
      dvh_sync_o <= {de_d, vsync_d, hsync_d};
      vid_rgb_o  <= rgb_d;
      hcount_o   <= h_q;
      vcount_o   <= v_q;
      sof_o      <= sof_d;
      if (h_q == H_LAST) begin
        h_q <= 12'd0;
        v_q <= (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end else begin
        h_q <= h_q + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Bench for video_timing_gen with a shrunken raster (24 x 13 total) so full
// frames fit in a short run. The reference model tracks only the linear
// pixel index within the frame and derives h, v and every output level from
// it with plain arithmetic and a colour table.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int SYNC_POL = 1;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOT * V_TOT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [1:0]  vh_blank;
  logic [2:0]  dvh_sync;
  logic [23:0] vid_rgb;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        sof;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen_i      (cen),
    .vh_blank_o (vh_blank),
    .dvh_sync_o (dvh_sync),
    .vid_rgb_o  (vid_rgb),
    .hcount_o   (hcount),
    .vcount_o   (vcount),
    .sof_o      (sof)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  bit started = 1'b0;  // an enabled edge has occurred since reset
  int p       = 0;     // linear index of the pixel currently presented

  logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d)", tag, obs, exp,
             p % H_TOT, p / H_TOT);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v);
    int b;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 24'h000000;
`ifdef VTG_COLOUR_BARS_EN
    b = h / (H_ACTIVE / 8);
    if (b > 7) b = 7;
    return bar_colour[b];
`else
    b = 0;
    return 24'h808080 + 24'(b);
`endif
  endfunction

  task automatic check_all();
    int h, v;
    logic on, off;
    on  = (SYNC_POL != 0);
    off = ~on;
    h = p % H_TOT;
    v = p / H_TOT;
    if (!started) begin
      chk("rst_blank", 32'(vh_blank), 32'(2'b11));
      chk("rst_sync",  32'(dvh_sync), 32'({1'b0, off, off}));
      chk("rst_rgb",   32'(vid_rgb),  32'h0);
      chk("rst_hcnt",  32'(hcount),   32'h0);
      chk("rst_vcnt",  32'(vcount),   32'h0);
      chk("rst_sof",   32'(sof),      32'h0);
    end else begin
      chk("blank", 32'(vh_blank), 32'({v >= V_ACTIVE, h >= H_ACTIVE}));
      chk("sync",  32'(dvh_sync),
          32'({(h < H_ACTIVE) && (v < V_ACTIVE),
               ((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC)) ? on : off,
               ((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC)) ? on : off}));
      chk("rgb",   32'(vid_rgb), 32'(model_rgb(h, v)));
      chk("hcnt",  32'(hcount),  32'(h));
      chk("vcnt",  32'(vcount),  32'(v));
      chk("sof",   32'(sof),     32'(p == 0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic c);
    rst = r;
    cen = c;
    @(posedge clk);
    if (r) begin
      started = 1'b0;
      p       = 0;
    end else if (c) begin
      if (!started) begin
        started = 1'b1;
        p       = 0;
      end else begin
        p = (p + 1) % FRAME;
      end
    end
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs_cnt, vs_cnt, sof_cnt, last_sof, gap_ok, sof_clk, found;

    // Reset held 3 cycles with cen high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);

    // First enabled edge presents (0,0) with sof and data enable.
    cyc(1'b0, 1'b1);
    chk("first_sof", 32'(sof), 32'h1);
    chk("first_de",  32'(dvh_sync[2]), 32'h1);

    // Two full frames with cen continuously high; measure pulse widths.
    hs_cnt = 0; vs_cnt = 0; sof_cnt = 0; last_sof = 0; gap_ok = 1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      cyc(1'b0, 1'b1);
      if (dvh_sync[0]) hs_cnt++;
      if (dvh_sync[1]) vs_cnt++;
      if (sof) begin
        sof_cnt++;
        if (i - last_sof != FRAME) gap_ok = 0;
        last_sof = i;
      end
    end
    chk("hsync_cycles", 32'(hs_cnt), 32'(2 * V_TOT * H_SYNC));
    chk("vsync_cycles", 32'(vs_cnt), 32'(2 * V_SYNC * H_TOT));
    chk("sof_count",    32'(sof_cnt), 32'd2);
    chk("sof_period",   32'(gap_ok), 32'd1);

    // cen toggling 1,0,1,0 over one frame of enabled cycles: each pixel lasts
    // two clocks, so sof stays high for two clocks.
    sof_clk = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1'b0, (i % 2) == 0);
      if (sof) sof_clk++;
    end
    chk("sof_toggle_clks", 32'(sof_clk), 32'd2);

    // Randomised enable with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)));
    end

    // Mid-frame reset at h=5, v=3 (bounded search), with cen low to show
    // that reset overrides the enable.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cyc(1'b0, 1'b1);
      if (started && p == 3 * H_TOT + 5) found = 1;
    end
    chk("reach_mid_frame", 32'(found), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("hold_after_rst_sof", 32'(sof), 32'h0);
    cyc(1'b0, 1'b1);
    chk("post_rst_sof",  32'(sof), 32'h1);
    chk("post_rst_hcnt", 32'(hcount), 32'h0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
